// File: rtl/mips_pkg.sv
// Shared register-file constants for the writeback arbiter and its scoreboard.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for destinations claimed by in-flight long-latency ops.
// A claim and a commit-clear of the same register at one edge leave it busy.
module rf_scoreboard
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    output logic                  issue_ready,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr1,
    input  logic [REG_ADDR_W-1:0] chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic [NUM_REGS-1:0]   busy
);

    logic [NUM_REGS-1:0] busy_next;

    assign issue_ready = issue_valid && (issue_addr == REG_ZERO || !busy[issue_addr]);
    assign chk_busy1   = busy[chk_addr1];
    assign chk_busy2   = busy[chk_addr2];

    // Next busy vector: clear from the commit stage first, so a new claim overrides it.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (issue_ready && issue_addr != REG_ZERO) begin
            busy_next[issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the pipeline writeback (A)
// and the long-latency unit (B); registers the winner into the commit stage.
module regfile_wb_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aValid,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic [DATA_W-1:0] aData,
    output logic              aReady,
    input  logic              bValid,
    input  logic [ADDR_W-1:0] bAddr,
    input  logic [DATA_W-1:0] bData,
    output logic              bReady,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueAddr,
    output logic              issueReady,
    input  logic [ADDR_W-1:0] chkAddr1,
    input  logic [ADDR_W-1:0] chkAddr2,
    output logic              chkBusy1,
    output logic              chkBusy2,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic              protocolErr
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    wait_cnt;
    logic                commit_is_b;
    logic                a_blocked;
    logic                starve;

    // A waits while B still owes a result to the same destination (WAW).
    assign a_blocked = (aAddr != REG_ZERO) && busy[aAddr];
    assign starve    = bValid && (wait_cnt == LIMIT);
    assign bReady    = bValid && (starve || !aValid || a_blocked);
    assign aReady    = aValid && !a_blocked && !starve;

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issueValid),
        .issue_addr  (issueAddr),
        .issue_ready (issueReady),
        .clr_en      (wrEn && commit_is_b),
        .clr_addr    (wrAddr),
        .chk_addr1   (chkAddr1),
        .chk_addr2   (chkAddr2),
        .chk_busy1   (chkBusy1),
        .chk_busy2   (chkBusy2),
        .busy        (busy)
    );

    // Count how long B has been waiting, saturating at the starvation limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (bValid && !bReady) begin
            if (wait_cnt != LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Commit stage: register the granted write; r0 writes are accepted but not enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrEn        <= 1'b0;
            wrAddr      <= '0;
            wrData      <= '0;
            commit_is_b <= 1'b0;
        end else if (aReady) begin
            wrEn        <= (aAddr != REG_ZERO);
            wrAddr      <= aAddr;
            wrData      <= aData;
            commit_is_b <= 1'b0;
        end else if (bReady) begin
            wrEn        <= (bAddr != REG_ZERO);
            wrAddr      <= bAddr;
            wrData      <= bData;
            commit_is_b <= 1'b1;
        end else begin
            wrEn        <= 1'b0;
            commit_is_b <= 1'b0;
        end
    end

    // Sticky flag for a B result landing on a register nobody claimed.
    always_ff @(posedge clk) begin
        if (rst) begin
            protocolErr <= 1'b0;
        end else if (bReady && bAddr != REG_ZERO && !busy[bAddr]) begin
            protocolErr <= 1'b1;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it between two writers:
  - requester A, the in-order pipeline writeback stage;
  - requester B, the long-latency unit (mul/div, uncached load return).
- Keeps a 32-bit busy scoreboard of destinations claimed by in-flight B operations. Issue and hazard logic use it to stall on RAW and WAW hazards.
- Drives the register file's write address, write data and write enable from a registered commit stage. The commit stage is also exported as a bypass source.

Parameters:
STARVE_LIMIT, 4, consecutive cycles B may wait before it preempts A (1..15)
DATA_W, 32, write data width
ADDR_W, 5, register address width (32 registers, r0 hardwired to zero)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
aValid  in  1  pipeline writeback request
aAddr  in  5  pipeline destination register
aData  in  32  pipeline write data
aReady  out  1  A accepted this cycle (combinational)
bValid  in  1  long-latency unit result valid
bAddr  in  5  long-latency destination register
bData  in  32  long-latency write data
bReady  out  1  B accepted this cycle (combinational)
issueValid  in  1  long-latency op issuing; claims issueAddr
issueAddr  in  5  destination to claim
issueReady  out  1  claim accepted (combinational)
chkAddr1  in  5  source register 1 to check
chkAddr2  in  5  source register 2 to check
chkBusy1  out  1  chkAddr1 pending in scoreboard
chkBusy2  out  1  chkAddr2 pending in scoreboard
wrEn  out  1  register file write enable (registered)
wrAddr  out  5  register file write address (registered)
wrData  out  32  register file write data (registered); also the bypass value
protocolErr  out  1  sticky error flag

Behaviour:
Reset:
- wrEn=0, wrAddr=0, wrData=0, protocolErr=0, busy=0, waitCnt=0.
- Reset mid-operation discards any pending claim and any commit; wrEn is low in the cycle after the reset edge.

Arbitration (combinational, evaluated every cycle):
- aBlocked = aAddr!=0 && busy[aAddr]. This is a WAW guard: A waits until B's result for that register commits.
- starve = bValid && waitCnt==STARVE_LIMIT.
- bReady = bValid && (starve || !aValid || aBlocked).
- aReady = aValid && !aBlocked && !starve.
- At most one of aReady and bReady is ever high.

waitCnt:
- Increments when bValid && !bReady, saturating at STARVE_LIMIT.
- Clears to 0 when bReady is high or bValid is low.

Commit stage:
- An accepted request is registered into wrAddr/wrData at the next edge. Latency is 1 cycle; the register file writes at the following edge.
- wrEn = accepted && addr!=0. Writes to r0 are accepted and dropped.
- One write can commit per cycle, so back-to-back grants give back-to-back commits. There is no backpressure from the register file.

Scoreboard (busy[31:0], busy[0] is constant 0):
- issueReady = issueValid && (issueAddr==0 || !busy[issueAddr]).
  - issueAddr==0 is accepted and sets nothing.
  - A claim on a busy register is refused and state is unchanged.
- Set: busy[issueAddr] is set at the edge where issueReady is high.
- Clear: busy[r] is cleared at the edge where the commit stage holds a B write to r with wrEn=1, i.e. the same edge the register file writes r. A reader therefore never sees busy=0 with stale data.
- Simultaneous clear and new claim of the same r at the same edge: the claim wins and busy[r] stays 1. issueReady uses pre-edge busy, so this only arises when busy[r] was already clear.
- chkBusyN = busy[chkAddrN]. No bypass from same-cycle issue; the issue stage owns that case.

protocolErr:
- Set, and held until reset, when B is accepted with bAddr!=0 && !busy[bAddr].
- The write is still performed.

Decomposition:
- Shared package mips_pkg holds REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, and REG_ZERO=5'd0.
- One natural sub-module: rf_scoreboard. It holds the busy vector, the set/clear/priority rules and the check ports.
- The arbiter, waitCnt and commit register stay in the top module.

Test Plan:
- A alone: aValid, aAddr=5, aData=0x1234 -> aReady=1; next cycle wrEn=1, wrAddr=5, wrData=0x1234. Then aAddr=0 -> aReady=1, wrEn=0.
- Claim and release: issue addr 8 -> chkBusy1(8)=1; bValid, bAddr=8, bData=0xCAFE with aValid=0 -> bReady=1; next cycle wrEn=1, wrData=0xCAFE; chkBusy1=0 only after that edge.
- Starvation: aValid held high to free regs, bValid held (bAddr=8 claimed) -> bReady=0 for 4 cycles, bReady=1 and aReady=0 in cycle 5; waitCnt=0 after.
- WAW block: addr 9 busy, aValid with aAddr=9, bValid with bAddr=9 -> aReady=0, bReady=1 same cycle; after B commits, aReady=1.
- Same-edge clear and reclaim: B commit of r3 while issueValid, issueAddr=3 arrives the following cycle -> issueReady=1, busy[3]=1; duplicate claim of a busy r3 -> issueReady=0.
- Error and reset: unclaimed bAddr=12 accepted -> protocolErr=1 and sticky; assert rst mid-claim -> all busy=0, wrEn=0, protocolErr=0 next cycle.
